// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bundle: ID-stage decode inputs, branch resolution, and the
// stage-aligned control, hazard and forwarding outputs.
interface ctrl_pipe_if;
  logic        id_valid;
  logic [11:0] id_ctrl;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        ex_br_taken;

  logic [11:0] ex_ctrl;
  logic [11:0] mem_ctrl;
  logic [11:0] wb_ctrl;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        halted;

  modport master (
    output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_br_taken,
    input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
    input  fwd_a, fwd_b, pc_write, ifid_write, ifid_flush, halted
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_br_taken,
    output ex_ctrl, mem_ctrl, wb_ctrl, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
    output fwd_a, fwd_b, pc_write, ifid_write, ifid_flush, halted
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-side ID/EX, EX/MEM, MEM/WB pipeline with hazard detection, branch
// flush, forwarding selects and a sticky halt.
module ctrl_pipe (
  input  logic         clk,
  input  logic         reset,
  ctrl_pipe_if.slave   bus
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
  logic [4:0]  r_ex_rs1, r_ex_rs2, r_ex_rd, r_mem_rd, r_wb_rd;

  logic        w_load_use, w_halt_inflight;
  logic        w_pc_write, w_ifid_write, w_ifid_flush;
  logic        w_advance, w_idex_bubble;
  logic [1:0]  w_fwd_a, w_fwd_b;

  assign w_load_use = r_ex_ctrl[3] && (r_ex_rd != 5'd0) && bus.id_valid &&
                      ((r_ex_rd == bus.id_rs1) || (r_ex_rd == bus.id_rs2));
  assign w_halt_inflight = r_ex_ctrl[11] | r_mem_ctrl[11] | r_wb_ctrl[11];

  // Priority: halted > branch flush > halt in flight > load-use > normal.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_advance     = 1'b1;
    w_idex_bubble = 1'b0;
    case (r_state)
      S_HALTED: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_advance    = 1'b0;
      end
      default: begin
        if (r_wb_ctrl[11])
          w_state_nxt = S_HALTED;
        if (bus.ex_br_taken) begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end else if (w_halt_inflight || w_load_use) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
        end else begin
          w_idex_bubble = !bus.id_valid;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_ex_ctrl  <= '0;
      r_ex_rs1   <= '0;
      r_ex_rs2   <= '0;
      r_ex_rd    <= '0;
      r_mem_ctrl <= '0;
      r_mem_rd   <= '0;
      r_wb_ctrl  <= '0;
      r_wb_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_advance) begin
        if (w_idex_bubble) begin
          r_ex_ctrl <= '0;
          r_ex_rs1  <= '0;
          r_ex_rs2  <= '0;
          r_ex_rd   <= '0;
        end else begin
          r_ex_ctrl <= bus.id_ctrl;
          r_ex_rs1  <= bus.id_rs1;
          r_ex_rs2  <= bus.id_rs2;
          r_ex_rd   <= bus.id_rd;
        end
        r_mem_ctrl <= r_ex_ctrl;
        r_mem_rd   <= r_ex_rd;
        r_wb_ctrl  <= r_mem_ctrl;
        r_wb_rd    <= r_mem_rd;
      end
    end
  end

  // EX/MEM result is newer than MEM/WB, so it is checked first.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_mem_ctrl[2] && (r_mem_rd != 5'd0) && (r_mem_rd == r_ex_rs1))
      w_fwd_a = 2'b10;
    else if (r_wb_ctrl[2] && (r_wb_rd != 5'd0) && (r_wb_rd == r_ex_rs1))
      w_fwd_a = 2'b01;
    if (r_mem_ctrl[2] && (r_mem_rd != 5'd0) && (r_mem_rd == r_ex_rs2))
      w_fwd_b = 2'b10;
    else if (r_wb_ctrl[2] && (r_wb_rd != 5'd0) && (r_wb_rd == r_ex_rs2))
      w_fwd_b = 2'b01;
  end

  assign bus.ex_ctrl    = r_ex_ctrl;
  assign bus.mem_ctrl   = r_mem_ctrl;
  assign bus.wb_ctrl    = r_wb_ctrl;
  assign bus.ex_rs1     = r_ex_rs1;
  assign bus.ex_rs2     = r_ex_rs2;
  assign bus.ex_rd      = r_ex_rd;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.wb_rd      = r_wb_rd;
  assign bus.fwd_a      = w_fwd_a;
  assign bus.fwd_b      = w_fwd_b;
  assign bus.pc_write   = w_pc_write;
  assign bus.ifid_write = w_ifid_write;
  assign bus.ifid_flush = w_ifid_flush;
  assign bus.halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: expectations are queued by the stimulus and
// compared by an independent negedge monitor.
module tb_ctrl_pipe;

  localparam int S_EXCTRL = 0,  S_MEMCTRL = 1, S_WBCTRL = 2,  S_EXRS1 = 3;
  localparam int S_EXRS2  = 4,  S_EXRD    = 5, S_MEMRD  = 6,  S_WBRD  = 7;
  localparam int S_FWDA   = 8,  S_FWDB    = 9, S_PCW    = 10, S_IFIDW = 11;
  localparam int S_FLUSH  = 12, S_HALTED  = 13;

  typedef struct {
    string       name;
    int          sel;
    logic [11:0] val;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic reset;

  ctrl_pipe_if bus ();

  ctrl_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] actual(int sel);
    case (sel)
      S_EXCTRL:  return bus.ex_ctrl;
      S_MEMCTRL: return bus.mem_ctrl;
      S_WBCTRL:  return bus.wb_ctrl;
      S_EXRS1:   return 12'(bus.ex_rs1);
      S_EXRS2:   return 12'(bus.ex_rs2);
      S_EXRD:    return 12'(bus.ex_rd);
      S_MEMRD:   return 12'(bus.mem_rd);
      S_WBRD:    return 12'(bus.wb_rd);
      S_FWDA:    return 12'(bus.fwd_a);
      S_FWDB:    return 12'(bus.fwd_b);
      S_PCW:     return 12'(bus.pc_write);
      S_IFIDW:   return 12'(bus.ifid_write);
      S_FLUSH:   return 12'(bus.ifid_flush);
      S_HALTED:  return 12'(bus.halted);
      default:   return 12'hxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (actual(e.sel) !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, actual(e.sel), e.val);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [11:0] val);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.val  = val;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [11:0] c,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.id_valid = v;
    bus.id_ctrl  = c;
    bus.id_rs1   = rs1;
    bus.id_rs2   = rs2;
    bus.id_rd    = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with arbitrary inputs
    reset = 1'b0;
    set_id(1'b1, 12'hFFF, 5'd5, 5'd5, 5'd5);
    bus.ex_br_taken = 1'b1;
    tick();
    set_id(1'b1, 12'h5A3, 5'd9, 5'd9, 5'd9);
    bus.ex_br_taken = 1'b0;
    tick();
    chk("rst_ex_ctrl", S_EXCTRL, 12'h000);
    chk("rst_mem_ctrl", S_MEMCTRL, 12'h000);
    chk("rst_wb_ctrl", S_WBCTRL, 12'h000);
    chk("rst_ex_rd", S_EXRD, 12'd0);
    chk("rst_mem_rd", S_MEMRD, 12'd0);
    chk("rst_wb_rd", S_WBRD, 12'd0);
    chk("rst_halted", S_HALTED, 12'd0);
    chk("rst_pc_write", S_PCW, 12'd1);
    chk("rst_fwd_a", S_FWDA, 12'd0);
    chk("rst_fwd_b", S_FWDB, 12'd0);

    // Release; R-type rd=5 flows ex -> mem -> wb
    reset = 1'b1;
    set_id(1'b1, 12'h004, 5'd1, 5'd2, 5'd5);
    chk("rel_flush", S_FLUSH, 12'd0);
    chk("rel_ifid_write", S_IFIDW, 12'd1);
    tick();
    set_id(1'b0, 12'h000, 5'd0, 5'd0, 5'd0);
    chk("r_ex_ctrl", S_EXCTRL, 12'h004);
    chk("r_ex_rd", S_EXRD, 12'd5);
    chk("r_ex_rs1", S_EXRS1, 12'd1);
    chk("r_ex_rs2", S_EXRS2, 12'd2);
    tick();
    chk("r_mem_ctrl", S_MEMCTRL, 12'h004);
    chk("r_mem_rd", S_MEMRD, 12'd5);
    chk("r_ex_bubble", S_EXCTRL, 12'h000);
    tick();
    chk("r_wb_ctrl", S_WBCTRL, 12'h004);
    chk("r_wb_rd", S_WBRD, 12'd5);
    chk("r_mem_bubble", S_MEMCTRL, 12'h000);

    // Load-use: lw x5 then add rs1=x5
    set_id(1'b1, 12'h00E, 5'd2, 5'd0, 5'd5);
    tick();
    set_id(1'b1, 12'h004, 5'd5, 5'd3, 5'd6);
    chk("lu_ex_ctrl", S_EXCTRL, 12'h00E);
    chk("lu_pc_write", S_PCW, 12'd0);
    chk("lu_ifid_write", S_IFIDW, 12'd0);
    chk("lu_flush", S_FLUSH, 12'd0);
    tick();
    chk("lu_bubble", S_EXCTRL, 12'h000);
    chk("lu_mem_ctrl", S_MEMCTRL, 12'h00E);
    chk("lu_pc_resume", S_PCW, 12'd1);
    tick();
    set_id(1'b0, 12'h000, 5'd0, 5'd0, 5'd0);
    chk("lu_add_ex", S_EXCTRL, 12'h004);
    chk("lu_add_rs1", S_EXRS1, 12'd5);
    chk("lu_fwd_a", S_FWDA, 12'b01);
    chk("lu_fwd_b", S_FWDB, 12'b00);

    // Forward priority on rs2=7
    set_id(1'b1, 12'h004, 5'd0, 5'd0, 5'd7);
    tick();
    set_id(1'b1, 12'h004, 5'd0, 5'd0, 5'd7);
    tick();
    set_id(1'b1, 12'h004, 5'd0, 5'd7, 5'd8);
    tick();
    chk("fp_both_fwd_b", S_FWDB, 12'b10);
    chk("fp_both_fwd_a", S_FWDA, 12'b00);
    set_id(1'b1, 12'h004, 5'd0, 5'd0, 5'd7);
    tick();
    set_id(1'b0, 12'h000, 5'd0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 12'h004, 5'd0, 5'd7, 5'd8);
    tick();
    chk("fp_memrd0", S_MEMRD, 12'd0);
    chk("fp_wb_fwd_b", S_FWDB, 12'b01);
    set_id(1'b1, 12'h004, 5'd8, 5'd0, 5'd9);
    tick();
    chk("fp_rs2_x0", S_FWDB, 12'b00);
    chk("fp_mem_fwd_a", S_FWDA, 12'b10);

    // Branch flush overriding load-use
    set_id(1'b1, 12'h00E, 5'd0, 5'd0, 5'd5);
    tick();
    set_id(1'b1, 12'h004, 5'd5, 5'd0, 5'd6);
    bus.ex_br_taken = 1'b1;
    chk("br_flush", S_FLUSH, 12'd1);
    chk("br_pc_write", S_PCW, 12'd1);
    chk("br_ifid_write", S_IFIDW, 12'd1);
    tick();
    bus.ex_br_taken = 1'b0;
    set_id(1'b1, 12'h881, 5'd0, 5'd0, 5'd0);   // halt in ID at cycle n
    chk("br_ex_bubble", S_EXCTRL, 12'h000);
    chk("br_mem_ctrl", S_MEMCTRL, 12'h00E);
    chk("br_mem_rd", S_MEMRD, 12'd5);
    chk("br_wb_rd", S_WBRD, 12'd9);
    chk("br_pc_after", S_PCW, 12'd1);

    // Halt sequence
    tick();                                    // n+1
    set_id(1'b1, 12'h004, 5'd1, 5'd2, 5'd10);
    chk("h1_ex_ctrl", S_EXCTRL, 12'h881);
    chk("h1_pc_write", S_PCW, 12'd0);
    chk("h1_ifid_write", S_IFIDW, 12'd0);
    tick();                                    // n+2
    chk("h2_ex_ctrl", S_EXCTRL, 12'h000);
    chk("h2_mem_ctrl", S_MEMCTRL, 12'h881);
    chk("h2_pc_write", S_PCW, 12'd0);
    tick();                                    // n+3
    chk("h3_wb_ctrl", S_WBCTRL, 12'h881);
    chk("h3_pc_write", S_PCW, 12'd0);
    chk("h3_halted", S_HALTED, 12'd0);
    tick();                                    // n+4
    bus.ex_br_taken = 1'b1;
    chk("h4_halted", S_HALTED, 12'd1);
    chk("h4_pc_write", S_PCW, 12'd0);
    chk("h4_ifid_write", S_IFIDW, 12'd0);
    chk("h4_flush", S_FLUSH, 12'd0);
    chk("h4_wb_ctrl", S_WBCTRL, 12'h000);
    tick();                                    // n+5, frozen
    chk("h5_halted", S_HALTED, 12'd1);
    chk("h5_ex_ctrl", S_EXCTRL, 12'h000);
    chk("h5_pc_write", S_PCW, 12'd0);

    // Reset clears halt
    reset = 1'b0;
    tick();
    bus.ex_br_taken = 1'b0;
    chk("hr_halted", S_HALTED, 12'd0);
    chk("hr_pc_write", S_PCW, 12'd1);
    chk("hr_ex_ctrl", S_EXCTRL, 12'h000);
    reset = 1'b1;
    set_id(1'b1, 12'h004, 5'd1, 5'd2, 5'd10);
    tick();
    chk("post_ex_ctrl", S_EXCTRL, 12'h004);
    chk("post_ex_rd", S_EXRD, 12'd10);

    tick();
    tick();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
